load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_byte_lane.sv | 35 +++
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] bytes;
        case (size)
            SIZE_BYTE: bytes = 4'd1;
            SIZE_HALF: bytes = 4'd2;
            SIZE_WORD: bytes = 4'd4;
            default:   bytes = 4'd8;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane datapath: load extract with zero/sign extension and
// read-modify-write merge of partial store data over the fetched doubleword.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [63:0] rdata_i,
    input  logic [63:0] wdata_i,
    output logic [63:0] load_data_o,
    output logic [63:0] store_data_o
);

    // NOTE: every output gets a default before the case/loop so no path leaves it unassigned (no latch).
    always_comb begin
        load_data_o = '0;
        case (size_i)
            SIZE_BYTE: load_data_o = {{56{signed_i & rdata_i[7]}},  rdata_i[7:0]};
            SIZE_HALF: load_data_o = {{48{signed_i & rdata_i[15]}}, rdata_i[15:0]};
            SIZE_WORD: load_data_o = {{32{signed_i & rdata_i[31]}}, rdata_i[31:0]};
            default:   load_data_o = rdata_i;
        endcase
    end

    // Bytes below the access size come from the store data, the rest keep memory contents.
    always_comb begin
        store_data_o = rdata_i;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < size_bytes(size_i)) begin
                store_data_o[8*i +: 8] = wdata_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a 64-bit little-endian data memory.
// Define LSU_ALIGN_CHECK_EN to also fault accesses not aligned to their size.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_address,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_address,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    lsu_state_e  state_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [63:0] resp_rdata_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [63:0] mem_address_q;
    logic [63:0] mem_wdata_q;

    logic [3:0]  req_bytes;
    logic [64:0] req_end;
    logic        bounds_fault;
    logic        align_fault;
    logic        req_fault;
    logic        accept;
    logic [63:0] load_data_d;
    logic [63:0] store_data_d;

    // The end address is one bit wider so an address near 2^64 cannot wrap into range.
    always_comb begin
        req_bytes    = size_bytes(req_size);
        req_end      = {1'b0, req_address} + {61'b0, req_bytes};
        bounds_fault = req_end > 65'(MEM_SIZE);
`ifdef LSU_ALIGN_CHECK_EN
        align_fault  = (req_address[2:0] & (req_bytes[2:0] - 3'd1)) != 3'd0;
`else
        align_fault  = 1'b0;
`endif
        req_fault    = bounds_fault | align_fault;
        accept       = req_valid & req_ready_q;
    end

    lsu_byte_lane u_byte_lane (
        .size_i       (size_q),
        .signed_i     (signed_q),
        .rdata_i      (mem_rdata),
        .wdata_i      (wdata_q),
        .load_data_o  (load_data_d),
        .store_data_o (store_data_d)
    );

    // NOTE: all state and outputs are registered with non-blocking assignments so every
    // register samples the pre-edge values; the async reset clears all of them.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            size_q        <= SIZE_BYTE;
            signed_q      <= 1'b0;
            write_q       <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_fault_q  <= 1'b0;
            resp_rdata_q  <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q      <= req_address;
                        wdata_q     <= req_wdata;
                        size_q      <= req_size;
                        signed_q    <= req_signed;
                        write_q     <= req_write;
                        req_ready_q <= 1'b0;
                        if (req_fault) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (!req_write || (req_size != SIZE_DOUBLE)) begin
                            // Loads and partial stores both need the current doubleword first.
                            state_q       <= ST_READ;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= req_address;
                        end else begin
                            state_q       <= ST_WRITE;
                            mem_write_q   <= 1'b1;
                            mem_address_q <= req_address;
                            mem_wdata_q   <= req_wdata;
                        end
                    end
                end

                ST_READ: begin
                    mem_read_q <= 1'b0;
                    if (write_q) begin
                        state_q       <= ST_WRITE;
                        mem_write_q   <= 1'b1;
                        mem_address_q <= addr_q;
                        mem_wdata_q   <= store_data_d;
                    end else begin
                        state_q       <= ST_RESP;
                        mem_address_q <= '0;
                        resp_valid_q  <= 1'b1;
                        resp_fault_q  <= 1'b0;
                        resp_rdata_q  <= load_data_d;
                    end
                end

                ST_WRITE: begin
                    state_q       <= ST_RESP;
                    mem_write_q   <= 1'b0;
                    mem_address_q <= '0;
                    mem_wdata_q   <= '0;
                    resp_valid_q  <= 1'b1;
                    resp_fault_q  <= 1'b0;
                    resp_rdata_q  <= '0;
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_fault_q <= 1'b0;
                        resp_rdata_q <= '0;
                        req_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_fault  = resp_fault_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model; expected
// values are hand-computed. Follows LSU_ALIGN_CHECK_EN for the misaligned case.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned MEM_SIZE = 256;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_address;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  mem [0:MEM_SIZE+7];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [63:0] last_raddr = '0;
    logic [63:0] last_waddr = '0;
    logic [63:0] last_wdata = '0;

    always #5 clock = ~clock;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_fault  (resp_fault),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always_comb begin
        logic [63:0] a;
        mem_rdata = '0;
        for (int i = 0; i < 8; i++) begin
            a = mem_address + 64'(i);
            if (a < 64'(MEM_SIZE + 8)) mem_rdata[8*i +: 8] = mem[a[8:0]];
        end
    end

    always @(posedge clock) begin
        logic [63:0] a;
        if (mem_read) begin
            rd_cnt++;
            last_raddr = mem_address;
        end
        if (mem_write) begin
            wr_cnt++;
            last_waddr = mem_address;
            last_wdata = mem_wdata;
            for (int i = 0; i < 8; i++) begin
                a = mem_address + 64'(i);
                if (a < 64'(MEM_SIZE + 8)) mem[a[8:0]] = mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [63:0] addr, input logic [63:0] wd);
        @(negedge clock);
        req_valid   = 1'b1;
        req_write   = wr;
        req_size    = sz;
        req_signed  = sg;
        req_address = addr;
        req_wdata   = wd;
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!resp_valid && lat < 20);
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
    endtask

    task automatic txn(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp_data, input logic exp_fault,
                       input int exp_lat, input int exp_rd, input int exp_wr);
        int lat;
        int rd0;
        int wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        send(wr, sz, sg, addr, wd);
        wait_resp(lat);
        check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " rdata"}, resp_rdata, exp_data);
        check({tag, " fault"}, 64'(resp_fault), 64'(exp_fault));
        check({tag, " reads"}, 64'(rd_cnt - rd0), 64'(exp_rd));
        check({tag, " writes"}, 64'(wr_cnt - wr0), 64'(exp_wr));
        ack();
        check({tag, " idle mem port"},
              mem_address | mem_wdata | {62'b0, mem_read, mem_write}, 64'd0);
        check({tag, " idle ready"}, 64'(req_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " ctrl"}, {59'b0, req_ready, resp_valid, resp_fault, mem_read, mem_write},
              64'b10000);
        check({tag, " data"}, mem_address | mem_wdata | resp_rdata, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        int          lat;
        int          rd0;
        int          wr0;

        for (int i = 0; i < MEM_SIZE + 8; i++) mem[i] = 8'h07;
        mem[16'h10] = 8'h80; mem[16'h11] = 8'h91; mem[16'h12] = 8'h22; mem[16'h13] = 8'hB3;
        mem[16'h14] = 8'h44; mem[16'h15] = 8'h55; mem[16'h16] = 8'h66; mem[16'h17] = 8'hF7;

        reset_n     = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_size    = SIZE_BYTE;
        req_signed  = 1'b0;
        req_address = '0;
        req_wdata   = '0;
        resp_ready  = 1'b0;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Loads of every size from 0x10 (bytes 80 91 22 B3 44 55 66 F7).
        txn("ldb_s",  1'b0, SIZE_BYTE,   1'b1, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2, 1, 0);
        check("ldb_s read addr", last_raddr, 64'h10);
        txn("ldb_u",  1'b0, SIZE_BYTE,   1'b0, 64'h10, 64'h0, 64'h0000_0000_0000_0080, 1'b0, 2, 1, 0);
        txn("ldh_s",  1'b0, SIZE_HALF,   1'b1, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_9180, 1'b0, 2, 1, 0);
        txn("ldw_s",  1'b0, SIZE_WORD,   1'b1, 64'h10, 64'h0, 64'hFFFF_FFFF_B322_9180, 1'b0, 2, 1, 0);
        txn("ldw_u",  1'b0, SIZE_WORD,   1'b0, 64'h10, 64'h0, 64'h0000_0000_B322_9180, 1'b0, 2, 1, 0);
        txn("ldd",    1'b0, SIZE_DOUBLE, 1'b0, 64'h10, 64'h0, 64'hF766_5544_B322_9180, 1'b0, 2, 1, 0);

        // Partial store read-modify-write, then readback.
        txn("sth",    1'b1, SIZE_HALF,   1'b0, 64'h20, 64'h1234_5678_9ABC_BEEF, 64'h0, 1'b0, 3, 1, 1);
        check("sth wdata", last_wdata, 64'h0707_0707_0707_BEEF);
        check("sth waddr", last_waddr, 64'h20);
        txn("sth rb", 1'b0, SIZE_DOUBLE, 1'b0, 64'h20, 64'h0, 64'h0707_0707_0707_BEEF, 1'b0, 2, 1, 0);

        // Double store skips the read.
        txn("sd",     1'b1, SIZE_DOUBLE, 1'b0, 64'h30, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 2, 0, 1);
        check("sd wdata", last_wdata, 64'h0123_4567_89AB_CDEF);
        txn("sd rb_b", 1'b0, SIZE_BYTE,  1'b1, 64'h37, 64'h0, 64'h0000_0000_0000_0001, 1'b0, 2, 1, 0);
        txn("sd rb_w", 1'b0, SIZE_WORD,  1'b0, 64'h34, 64'h0, 64'h0000_0000_0123_4567, 1'b0, 2, 1, 0);

        txn("sw",     1'b1, SIZE_WORD,   1'b0, 64'h38, 64'hFFFF_FFFF_CAFE_F00D, 64'h0, 1'b0, 3, 1, 1);
        check("sw wdata", last_wdata, 64'h0707_0707_CAFE_F00D);
        txn("sw rb",  1'b0, SIZE_WORD,   1'b1, 64'h38, 64'h0, 64'hFFFF_FFFF_CAFE_F00D, 1'b0, 2, 1, 0);

        // Bounds: last legal doubleword, straddling the end, top byte, past the end, wrap.
        txn("ldd_f8", 1'b0, SIZE_DOUBLE, 1'b0, 64'hF8, 64'h0, 64'h0707_0707_0707_0707, 1'b0, 2, 1, 0);
        txn("ldd_fc", 1'b0, SIZE_DOUBLE, 1'b0, 64'hFC, 64'h0, 64'h0, 1'b1, 1, 0, 0);
        txn("ldb_ff", 1'b0, SIZE_BYTE,   1'b0, 64'hFF, 64'h0, 64'h07, 1'b0, 2, 1, 0);
        txn("ldb_100", 1'b0, SIZE_BYTE,  1'b0, 64'h100, 64'h0, 64'h0, 1'b1, 1, 0, 0);
        txn("ldb_wrap", 1'b0, SIZE_BYTE, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b1, 1, 0, 0);
        txn("sd_f9",  1'b1, SIZE_DOUBLE, 1'b0, 64'hF9, 64'hDEAD, 64'h0, 1'b1, 1, 0, 0);
        txn("sb_100", 1'b1, SIZE_BYTE,   1'b0, 64'h100, 64'hAA, 64'h0, 1'b1, 1, 0, 0);

`ifdef LSU_ALIGN_CHECK_EN
        txn("ldw_22", 1'b0, SIZE_WORD,   1'b0, 64'h22, 64'h0, 64'h0, 1'b1, 1, 0, 0);
`else
        txn("ldw_22", 1'b0, SIZE_WORD,   1'b0, 64'h22, 64'h0, 64'h0000_0000_0707_0707, 1'b0, 2, 1, 0);
`endif

        // Response backpressure with a competing request held on the input.
        rd0 = rd_cnt;
        send(1'b0, SIZE_DOUBLE, 1'b0, 64'h10, 64'h0);
        wait_resp(lat);
        check("bp latency", 64'(lat), 64'd2);
        check("bp rdata", resp_rdata, 64'hF766_5544_B322_9180);
        held = resp_rdata;
        req_valid   = 1'b1;
        req_write   = 1'b0;
        req_size    = SIZE_BYTE;
        req_signed  = 1'b0;
        req_address = 64'h13;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp valid held", 64'(resp_valid), 64'd1);
            check("bp rdata held", resp_rdata, held);
            check("bp ready low", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        check("bp after hs valid", 64'(resp_valid), 64'd0);
        check("bp after hs ready", 64'(req_ready), 64'd1);
        check("bp no early accept", 64'(rd_cnt - rd0), 64'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        check("bp second latency", 64'(lat), 64'd2);
        check("bp second rdata", resp_rdata, 64'h0000_0000_0000_00B3);
        ack();

        // Reset during READ of a partial store aborts it.
        wr0 = wr_cnt;
        send(1'b1, SIZE_BYTE, 1'b0, 64'h50, 64'hAA);
        @(negedge clock);
        check("rst in READ mem_read", 64'(mem_read), 64'd1);
        reset_n = 1'b0;
        #1 check_reset_outputs("rst in READ");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("rst no write", 64'(wr_cnt - wr0), 64'd0);
        check("rst no resp", 64'(resp_valid), 64'd0);
        txn("rst rb", 1'b0, SIZE_BYTE, 1'b0, 64'h50, 64'h0, 64'h07, 1'b0, 2, 1, 0);

        // A write already done before reset stands.
        send(1'b1, SIZE_DOUBLE, 1'b0, 64'h60, 64'h1122_3344_5566_7788);
        @(negedge clock);
        check("stand mem_write", 64'(mem_write), 64'd1);
        @(negedge clock);
        reset_n = 1'b0;
        #1 check_reset_outputs("rst in RESP");
        @(negedge clock);
        reset_n = 1'b1;
        txn("stand rb", 1'b0, SIZE_DOUBLE, 1'b0, 64'h60, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
